// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the parallel LCD bus (controller and receiver sides).
package lcd_bus_pkg;

  typedef logic [7:0] lcd_byte_t;

  localparam int unsigned DefaultDepth         = 4;
  localparam int unsigned DefaultMinHighCycles = 3;

  // HD44780-style command bytes issued by lcd_controller.
  typedef enum logic [7:0] {
    CmdClear       = 8'h01,
    CmdHome        = 8'h02,
    CmdEntryMode   = 8'h06,
    CmdDisplayOn   = 8'h0C,
    CmdFunctionSet = 8'h38,
    CmdSetDdram    = 8'h80
  } lcd_cmd_e;

endpackage

// File: rtl/lcd_rx_fifo.sv
// Small byte FIFO with a registered head; pointers carry an extra wrap bit for full/empty.
module lcd_rx_fifo
  import lcd_bus_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth
) (
  input  logic      clk_i,
  input  logic      reset_n_i,
  input  logic      push_i,
  input  lcd_byte_t push_data_i,
  input  logic      pop_i,
  input  logic      flush_i,
  output logic      full_o,
  output logic      empty_o,
  output lcd_byte_t head_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  typedef logic [AddrW:0] ptr_t;

  lcd_byte_t mem_q [Depth];
  lcd_byte_t head_q;
  ptr_t      wr_ptr_q, wr_ptr_d;
  ptr_t      rd_ptr_q, rd_ptr_d;
  logic      do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data_i;
  end

  // Head tracks the slot the read pointer will address; bypass the write when it lands there.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head_q <= '0;
    end else if (do_push && !flush_i && (wr_ptr_q[AddrW-1:0] == rd_ptr_d[AddrW-1:0])) begin
      head_q <= push_data_i;
    end else begin
      head_q <= mem_q[rd_ptr_d[AddrW-1:0]];
    end
  end

endmodule

// File: rtl/lcd_bus_receiver.sv
// Display-side endpoint of the LCD bus: synchronizes the pins, qualifies enable strobes
// by width and queues each byte latched on a valid enable falling edge.
module lcd_bus_receiver
  import lcd_bus_pkg::*;
#(
  parameter int unsigned Depth         = DefaultDepth,
  parameter int unsigned MinHighCycles = DefaultMinHighCycles
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  lcd_byte_t   lcd_data_i,
  input  logic        lcd_reset_i,
  input  logic        lcd_enable_i,
  output lcd_byte_t   data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overflow_o,
  output logic        glitch_o,
  output logic [15:0] byte_count_o
);

  localparam int unsigned WidthW = $clog2(MinHighCycles + 1);
  typedef logic [WidthW-1:0] width_t;
  localparam width_t WidthMax = width_t'(MinHighCycles);

  logic      en_s1_q, en_s2_q, en_s3_q;
  logic      rst_s1_q, rst_s2_q;
  lcd_byte_t data_s1_q, data_s2_q, data_s3_q;

  width_t      width_q, width_d;
  logic [15:0] count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        glitch_q, glitch_d;

  logic fall, qualified, push, pop, accept, fifo_full, fifo_empty;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      en_s1_q   <= 1'b0;
      en_s2_q   <= 1'b0;
      en_s3_q   <= 1'b0;
      rst_s1_q  <= 1'b0;
      rst_s2_q  <= 1'b0;
      data_s1_q <= '0;
      data_s2_q <= '0;
      data_s3_q <= '0;
    end else begin
      en_s1_q   <= lcd_enable_i;
      en_s2_q   <= en_s1_q;
      en_s3_q   <= en_s2_q;
      rst_s1_q  <= lcd_reset_i;
      rst_s2_q  <= rst_s1_q;
      data_s1_q <= lcd_data_i;
      data_s2_q <= data_s1_q;
      data_s3_q <= data_s2_q;
    end
  end

  // data_s3 is one stage behind en_s2, so on the fall cycle it holds the last high-cycle byte.
  assign fall      = en_s3_q & ~en_s2_q;
  assign qualified = (width_q >= WidthMax);
  assign push      = fall & ~rst_s2_q & qualified;
  assign valid_o   = ~fifo_empty;
  assign pop       = valid_o & ready_i;
  assign accept    = push & (~fifo_full | pop);

  always_comb begin
    width_d    = width_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & fifo_full & ~pop);
    glitch_d   = fall & ~rst_s2_q & ~qualified;
    if (rst_s2_q) begin
      width_d = '0;
      count_d = '0;
    end else begin
      if (fall) begin
        width_d = '0;
      end else if (en_s2_q && (width_q < WidthMax)) begin
        width_d = width_q + width_t'(1);
      end
      if (accept) count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      width_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      width_q    <= width_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      glitch_q   <= glitch_d;
    end
  end

  assign overflow_o   = overflow_q;
  assign glitch_o     = glitch_q;
  assign byte_count_o = count_q;

  lcd_rx_fifo #(
    .Depth(Depth)
  ) u_fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .push_i     (push),
    .push_data_i(data_s3_q),
    .pop_i      (pop),
    .flush_i    (rst_s2_q),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (data_o)
  );

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Receive-side endpoint of the parallel LCD bus driven by `lcd_controller`: samples the 8-bit data, reset and enable lines from a second icebreaker (via PMOD) or a loopback, and captures one byte on every qualified enable falling edge. Captured bytes go into a small FIFO and are presented on a valid/ready stream. It is used on-board to check controller output and as a synthesizable display-side model in benches.

## Interface

Parameters:
- `Depth`, 4: FIFO entries; power of two, ≥2.
- `MinHighCycles`, 3: minimum synchronized enable-high width, in `clk_i` cycles, for a strobe to count.

Ports:
- `clk_i` in 1: single clock, 12 MHz on board.
- `reset_n_i` in 1: reset is synchronous and active-low.
- `lcd_data_i` in 8: asynchronous bus data.
- `lcd_reset_i` in 1: asynchronous bus reset, active-high.
- `lcd_enable_i` in 1: asynchronous bus strobe; the byte is latched on the falling edge.
- `data_o` out 8: head-of-FIFO byte.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer pops when `valid_o & ready_i`.
- `overflow_o` out 1: sticky; a byte was dropped because the FIFO was full.
- `glitch_o` out 1: one-cycle pulse when a strobe shorter than `MinHighCycles` is discarded.
- `byte_count_o` out 16: bytes accepted into the FIFO since reset; wraps from 0xFFFF to 0.

## Operation

- Synchronizers: `lcd_enable_i`, `lcd_reset_i` and all 8 `lcd_data_i` bits pass through 2 flops (s1, s2). A third stage s3 holds enable and data.
- Fall detect: `en_s3 == 1 && en_s2 == 0`. The captured byte is `data_s3`, which is the data seen during the last high cycle.
- Width counter: counts cycles with `en_s2 == 1` and saturates at `MinHighCycles`. It clears on the cycle after a fall.
  - On a fall with count ≥ `MinHighCycles`: push `data_s3`.
  - On a fall with count < `MinHighCycles`: drop the byte and pulse `glitch_o`.
- Bus reset (`rst_s2 == 1`), held every cycle it is active:
  - flush the FIFO, so `valid_o` is 0 next cycle;
  - clear the width counter and `byte_count_o`;
  - ignore falls.
  - `overflow_o` is not cleared by bus reset; only `reset_n_i` clears it.
- FIFO push when full:
  - If a pop happens in the same cycle, push and pop both proceed and occupancy is unchanged.
  - Otherwise the byte is dropped, `overflow_o` is set, and `byte_count_o` does not increment.
- Pop and push on an empty FIFO: the new byte appears on `data_o` the next cycle. There is no fall-through.
- `data_o` is undefined-but-stable when `valid_o` is 0. It is driven to 0 after reset.
- Holding `ready_i` high with `valid_o` low has no effect.

## Timing

- Reset values (after any `reset_n_i` low edge): `valid_o` 0, `data_o` 0, `overflow_o` 0, `glitch_o` 0, `byte_count_o` 0. All sync/stage flops are 0, so enable is treated as low and no spurious fall occurs.
- `reset_n_i` asserted mid-strobe: everything clears. A strobe still high after release needs a full `MinHighCycles` of high time before its fall counts.
- Latency: the enable pin falls before edge k. `en_s2` is low after edge k+1, the push happens at edge k+2, and `valid_o` is 1 after edge k+2.
  - Worst case is 3 edges, including sampling uncertainty.
- Data must be stable at the pins for ≥2 cycles before and through the enable fall.
- `byte_count_o` updates on the same edge as the push.
- `glitch_o` is high for exactly the cycle after the discarded fall.
- Pop: `data_o` and `valid_o` update on the edge where `valid_o & ready_i`.
- Back-to-back strobes: full rate is one byte per `MinHighCycles + 1` cycles.

## Structure

- Package `lcd_bus_pkg`: `lcd_byte_t` (8-bit), default `Depth`/`MinHighCycles`, and the shared LCD command codes also used by `lcd_controller`.
- Sub-module `lcd_rx_fifo`:
  - parameterized on `Depth`, 8-bit;
  - ports: push, pop, flush, full, empty, head data;
  - pointers one bit wider than log2(`Depth`).
- The top level holds the synchronizers, fall detect, width counter, byte counter and overflow/glitch logic.

## Test plan

- Reset: `reset_n_i` low for 2 cycles with enable high → all outputs 0. After release, enable low within 1 cycle → no push, `glitch_o` pulses because the width was < 3.
- Single byte: data 0x41, enable high 5 cycles then low, `ready_i` 0 → `valid_o`=1, `data_o`=0x41 within 3 cycles of the fall, `byte_count_o`=1.
- Glitch: enable high 2 cycles with data 0x55 → `glitch_o` pulses once, `valid_o` stays 0, count unchanged.
- Overflow: 5 valid strobes (0x01–0x05) with `ready_i`=0 and `Depth`=4 → `overflow_o`=1. Pops then return 0x01–0x04, and `byte_count_o`=4.
- Full with simultaneous pop: FIFO full, `ready_i`=1 on the push cycle → no overflow, occupancy stays 4, order preserved.
- Bus reset: 3 bytes queued, then `lcd_reset_i` high 4 cycles → `valid_o`=0 within 3 cycles, count 0. A strobe during reset is ignored. The next strobe after release is accepted.
